desc_word_packer: RTL

//  Transmit side of the descriptor load interface of the NCC matcher. Accepts a

---
 rtl/desc_word_packer_if.sv | 38 +++
 rtl/desc_word_packer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/desc_word_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : desc_word_packer_if
//  Description : Pixel-in / descriptor-word-out bundle for desc_word_packer.
//                The master side drives control and the pixel stream; the
//                slave side (the packer) returns the packed words and strobes.
//  Revision    : 1.0  initial release
// ============================================================================
interface desc_word_packer_if #(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 4
);
    // Control
    logic                            start;
    logic                            abort;
    // Upstream pixel stream
    logic                            pix_valid;
    logic [PIX_W-1:0]                pix_data;
    logic                            pix_ready;
    // Downstream descriptor load
    logic [PIX_W*PIX_PER_WORD-1:0]   desc_data;
    logic                            desc_data_ready;
    logic                            load_acc_reg;
    // Status
    logic                            busy;
    logic                            done;

    modport master (
        output start, abort, pix_valid, pix_data,
        input  pix_ready, desc_data, desc_data_ready, load_acc_reg, busy, done
    );

    modport slave (
        input  start, abort, pix_valid, pix_data,
        output pix_ready, desc_data, desc_data_ready, load_acc_reg, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/desc_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : desc_word_packer
//  Description : Packs a serial pixel stream into PIX_PER_WORD-pixel words
//                (first pixel in the MSB lane), strobes each word to the NCC
//                core and pulses load_acc_reg/done once a full descriptor of
//                DESC_PIXELS pixels has been delivered. The core has no
//                backpressure, so all sequencing is owned here.
//  Revision    : 1.0  initial release
// ============================================================================
module desc_word_packer #(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int DESC_PIXELS  = 64   // multiple of PIX_PER_WORD, PIX_PER_WORD >= 2
) (
    input  wire logic          clk,
    input  wire logic          rst,   // asynchronous, active-low
    desc_word_packer_if.slave  bus
);

    localparam int c_WORD_W  = PIX_W * PIX_PER_WORD;
    localparam int c_SHIFT_W = c_WORD_W - PIX_W;          // lanes held before the last pixel
    localparam int c_WORDS   = DESC_PIXELS / PIX_PER_WORD;
    localparam int c_LANE_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int c_WCNT_W  = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;

    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(PIX_PER_WORD - 1);
    localparam logic [c_WCNT_W-1:0] c_LAST_WORD = c_WCNT_W'(c_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FLUSH = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [c_LANE_W-1:0]    r_lane_cnt;
    logic [c_WCNT_W-1:0]    r_word_cnt;
    logic [c_SHIFT_W-1:0]   r_shift;
    logic [c_WORD_W-1:0]    r_desc_data;
    logic                   r_desc_ready;

    logic                   w_accept;
    logic                   w_lane_last;
    logic                   w_last_pix;
    logic                   w_word_emit;
    logic                   w_start_ok;

    // Handshake and word-boundary decode
    assign w_accept    = bus.pix_valid && (r_state == S_FILL);
    assign w_lane_last = (r_lane_cnt == c_LAST_LANE);
    assign w_last_pix  = w_accept && w_lane_last && (r_word_cnt == c_LAST_WORD);
    assign w_word_emit = w_accept && w_lane_last && !bus.abort;
    assign w_start_ok  = (r_state == S_IDLE) && bus.start && !bus.abort;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        w_state_next = r_state;
        if (bus.abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.start) w_state_next = S_FILL;
                S_FILL:  if (w_last_pix) w_state_next = S_FLUSH;
                S_FLUSH: w_state_next = S_LOAD;
                S_LOAD:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Lane/word counters: cleared on a new descriptor or abort, stepped per accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lane_cnt <= '0;
            r_word_cnt <= '0;
        end else if (bus.abort || w_start_ok) begin
            r_lane_cnt <= '0;
            r_word_cnt <= '0;
        end else if (w_accept) begin
            if (w_lane_last) begin
                r_lane_cnt <= '0;
                r_word_cnt <= r_word_cnt + c_WCNT_W'(1);
            end else begin
                r_lane_cnt <= r_lane_cnt + c_LANE_W'(1);
            end
        end
    end

    // Lane shift register: older pixels migrate toward the MSB lanes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
        end else if (w_accept && !bus.abort) begin
            r_shift <= c_SHIFT_W'({r_shift, bus.pix_data});
        end
    end

    // Output word register and its one-cycle strobe; the word holds until the next emit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_desc_data  <= '0;
            r_desc_ready <= 1'b0;
        end else begin
            r_desc_ready <= w_word_emit;
            if (w_word_emit) begin
                r_desc_data <= {r_shift, bus.pix_data};
            end
        end
    end

    assign bus.pix_ready       = (r_state == S_FILL);
    assign bus.busy            = (r_state != S_IDLE);
    assign bus.load_acc_reg    = (r_state == S_LOAD);
    assign bus.done            = (r_state == S_LOAD);
    assign bus.desc_data       = r_desc_data;
    assign bus.desc_data_ready = r_desc_ready;

endmodule
`default_nettype wire
